alu_sweep_driver: RTL and testbench
===================================

// Module: alu_sweep_driver
// PURPOSE
//  Hardware sequencer at the driving end of the ALU port set (A, B, carry_in, is_shift, scode, acode -> R, zero, carry_out).
//  On start it latches one operand set and sweeps every arith code (acode 0..7) or every shift code (scode 0..3).
//  For each code it drives the combinational ALU, waits SETTLE cycles, then captures R/zero/carry_out.
//  Each capture is presented on a valid/ready result stream. Used for in-system ALU self-test alongside the SCMIPS datapath.
// PARAMETERS
//  WIDTH   8  operand/result width; matches ALU A/B/R
//  SETTLE  1  cycles ALU inputs are held before capture; legal range >=1
// PORTS
//  clk            in   1      clock; all state changes on rising edge
//  rst_n          in   1      asynchronous active-low reset
//  start          in   1      begin sweep; sampled only in IDLE
//  abort          in   1      synchronous cancel; returns to IDLE
//  mode           in   1      0 = arith sweep (acode), 1 = shift sweep (scode)
//  a_in           in   WIDTH  operand A, latched on accepted start
//  b_in           in   WIDTH  operand B, latched on accepted start
//  cin_in         in   1      carry_in, latched on accepted start
//  alu_a          out  WIDTH  to ALU A
//  alu_b          out  WIDTH  to ALU B
//  alu_cin        out  1      to ALU carry_in
//  alu_is_shift   out  1      to ALU is_shift (= latched mode)
//  alu_scode      out  2      to ALU scode
//  alu_acode      out  3      to ALU acode
//  alu_r          in   WIDTH  from ALU R
//  alu_zero       in   1      from ALU zero
//  alu_cout       in   1      from ALU carry_out
//  out_valid      out  1      result available
//  out_ready      in   1      consumer accepts result
//  res_code       out  3      code that produced the result
//  res_r          out  WIDTH  captured R
//  res_zero       out  1      captured zero
//  res_cout       out  1      captured carry_out
//  busy           out  1      state != IDLE
//  done           out  1      one-cycle pulse after last result accepted
//  zero_count     out  4      number of captured results with zero=1 in current/last sweep
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE. Every output and internal register = 0, including zero_count.
//  Reset is honoured in any state; a sweep in progress is lost with no done pulse.
//  FSM states: IDLE, DRIVE, PRESENT, DONE.
//  IDLE:
//   - start=1 and abort=0 -> latch a_in/b_in/cin_in/mode; code=0; settle cnt=0; zero_count=0; -> DRIVE.
//   - abort has priority over start.
//  DRIVE:
//   - alu_* driven from latched regs.
//   - Arith mode: alu_acode=code, alu_scode=0. Shift mode: alu_scode=code[1:0], alu_acode=0.
//   - cnt increments each cycle. At the edge where cnt==SETTLE-1: capture res_r/res_zero/res_cout and res_code=code.
//   - On that capture edge, zero_count += alu_zero, then -> PRESENT.
//  PRESENT:
//   - out_valid=1; res_* held stable until the handshake completes.
//   - Handshake = out_valid & out_ready at a rising edge.
//   - On handshake with code==LAST (7 arith, 3 shift) -> DONE.
//   - On handshake otherwise: code+1, cnt=0 -> DRIVE.
//  DONE: done=1 for exactly one cycle -> IDLE. zero_count holds until the next accepted start.
//  abort=1 in DRIVE/PRESENT/DONE: -> IDLE at next edge. No done pulse. out_valid drops.
//   - A handshake coincident with abort counts as accepted; no further results follow.
//  alu_* outputs retain their last values in IDLE/DONE. start outside IDLE is ignored.
//  Latency: out_valid rises SETTLE edges after the start edge (also after each handshake edge).
//   - With out_ready held 1, each result costs SETTLE+1 cycles.
//   - A full sweep costs 8*(SETTLE+1)+1 cycles arith, 4*(SETTLE+1)+1 shift.
//  res_code wraps never: counter stops at LAST. zero_count max 8 fits 4 bits.
// TESTING (bench ALU stub: R = A+acode+scode mod 256, zero=(R==0), carry_out = carry of that add)
//  1 Reset mid-PRESENT -> out_valid, busy, res_r, zero_count all 0 immediately; IDLE after release.
//  2 SETTLE=1, A=8'hFB, mode=0, out_ready=1 -> res_r FB,FC,FD,FE,FF,00,01,02.
//     Expected flags: res_cout=1 for codes 5..7; zero_count=1; done pulse 17 cycles after start.
//  3 A=8'h10, mode=1 -> res_code 0..3, res_r 10..13; alu_acode stays 0; done after 4 results.
//  4 out_ready low 5 cycles in PRESENT on code 2 -> res_r/res_code stable, no code skipped or repeated.
//  5 abort on code 4 PRESENT with out_ready=1 -> code 4 accepted, busy=0 next cycle, no done.
//     Also: start during busy is ignored.
//  6 SETTLE=3 -> alu_acode held 3 cycles per code; out_valid 3 edges after start; start+abort same cycle -> stays IDLE.

Source files
------------

// File: rtl/alu_sweep_driver.sv
// Drives a combinational ALU through every arith code (0..7) or shift code (0..3) for one
// latched operand set, and presents each captured result on a valid/ready stream.
module alu_sweep_driver #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic             alu_is_shift,
  output logic [1:0]       alu_scode,
  output logic [2:0]       alu_acode,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_zero,
  input  logic             alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       res_code,
  output logic [WIDTH-1:0] res_r,
  output logic             res_zero,
  output logic             res_cout,
  output logic             busy,
  output logic             done,
  output logic [3:0]       zero_count
);

  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DRIVE   = 2'd1;
  localparam logic [1:0] PRESENT = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       code_q, code_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic             alu_cin_q, alu_cin_d;
  logic             alu_is_shift_q, alu_is_shift_d;
  logic [1:0]       alu_scode_q, alu_scode_d;
  logic [2:0]       alu_acode_q, alu_acode_d;
  logic             out_valid_q, out_valid_d;
  logic [2:0]       res_code_q, res_code_d;
  logic [WIDTH-1:0] res_r_q, res_r_d;
  logic             res_zero_q, res_zero_d;
  logic             res_cout_q, res_cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       zero_count_q, zero_count_d;
  logic [2:0]       code_last;
  logic [2:0]       code_nxt;

  // Next-state and register update logic; the alu_* registers double as the operand latch.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    code_d         = code_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_cin_d      = alu_cin_q;
    alu_is_shift_d = alu_is_shift_q;
    alu_scode_d    = alu_scode_q;
    alu_acode_d    = alu_acode_q;
    res_code_d     = res_code_q;
    res_r_d        = res_r_q;
    res_zero_d     = res_zero_q;
    res_cout_d     = res_cout_q;
    zero_count_d   = zero_count_q;
    code_last      = alu_is_shift_q ? 3'd3 : 3'd7;
    code_nxt       = code_q + 3'd1;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d        = DRIVE;
          alu_a_d        = a_in;
          alu_b_d        = b_in;
          alu_cin_d      = cin_in;
          alu_is_shift_d = mode;
          alu_scode_d    = 2'd0;
          alu_acode_d    = 3'd0;
          code_d         = 3'd0;
          cnt_d          = '0;
          zero_count_d   = 4'd0;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = PRESENT;
          res_code_d   = code_q;
          res_r_d      = alu_r;
          res_zero_d   = alu_zero;
          res_cout_d   = alu_cout;
          zero_count_d = zero_count_q + 4'(alu_zero);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESENT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready) begin
          if (code_q == code_last) begin
            state_d = DONE;
          end else begin
            state_d     = DRIVE;
            code_d      = code_nxt;
            cnt_d       = '0;
            alu_acode_d = alu_is_shift_q ? 3'd0 : code_nxt;
            alu_scode_d = alu_is_shift_q ? code_nxt[1:0] : 2'd0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d != IDLE);
    out_valid_d = (state_d == PRESENT);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      code_q         <= 3'd0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_cin_q      <= 1'b0;
      alu_is_shift_q <= 1'b0;
      alu_scode_q    <= 2'd0;
      alu_acode_q    <= 3'd0;
      out_valid_q    <= 1'b0;
      res_code_q     <= 3'd0;
      res_r_q        <= '0;
      res_zero_q     <= 1'b0;
      res_cout_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      zero_count_q   <= 4'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      code_q         <= code_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_cin_q      <= alu_cin_d;
      alu_is_shift_q <= alu_is_shift_d;
      alu_scode_q    <= alu_scode_d;
      alu_acode_q    <= alu_acode_d;
      out_valid_q    <= out_valid_d;
      res_code_q     <= res_code_d;
      res_r_q        <= res_r_d;
      res_zero_q     <= res_zero_d;
      res_cout_q     <= res_cout_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      zero_count_q   <= zero_count_d;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_cin      = alu_cin_q;
  assign alu_is_shift = alu_is_shift_q;
  assign alu_scode    = alu_scode_q;
  assign alu_acode    = alu_acode_q;
  assign out_valid    = out_valid_q;
  assign res_code     = res_code_q;
  assign res_r        = res_r_q;
  assign res_zero     = res_zero_q;
  assign res_cout     = res_cout_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign zero_count   = zero_count_q;

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Directed bench for alu_sweep_driver: SETTLE=1 and SETTLE=3 instances share stimulus,
// each closed around an adder-style ALU stub.
module tb_alu_sweep_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] a_in = 8'h00;
  logic [7:0] b_in = 8'h00;
  logic       cin_in = 1'b0;
  logic       out_ready = 1'b0;

  logic [7:0] alu_a, alu_b, alu_r, res_r;
  logic       alu_cin, alu_is_shift, alu_zero, alu_cout;
  logic [1:0] alu_scode;
  logic [2:0] alu_acode, res_code;
  logic       out_valid, res_zero, res_cout, busy, done;
  logic [3:0] zero_count;

  logic [7:0] alu_a2, alu_b2, alu_r2, res_r2;
  logic       alu_cin2, alu_is_shift2, alu_zero2, alu_cout2;
  logic [1:0] alu_scode2;
  logic [2:0] alu_acode2, res_code2;
  logic       out_valid2, res_zero2, res_cout2, busy2, done2;
  logic [3:0] zero_count2;

  logic [8:0] sum1, sum2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // ALU stub: R = A + acode + scode mod 256
  assign sum1     = {1'b0, alu_a} + 9'(alu_acode) + 9'(alu_scode);
  assign alu_r    = sum1[7:0];
  assign alu_cout = sum1[8];
  assign alu_zero = (sum1[7:0] == 8'h00);
  assign sum2      = {1'b0, alu_a2} + 9'(alu_acode2) + 9'(alu_scode2);
  assign alu_r2    = sum2[7:0];
  assign alu_cout2 = sum2[8];
  assign alu_zero2 = (sum2[7:0] == 8'h00);

  alu_sweep_driver #(.WIDTH(8), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_is_shift(alu_is_shift),
    .alu_scode(alu_scode), .alu_acode(alu_acode),
    .alu_r(alu_r), .alu_zero(alu_zero), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready), .res_code(res_code), .res_r(res_r),
    .res_zero(res_zero), .res_cout(res_cout), .busy(busy), .done(done),
    .zero_count(zero_count)
  );

  alu_sweep_driver #(.WIDTH(8), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_cin(alu_cin2), .alu_is_shift(alu_is_shift2),
    .alu_scode(alu_scode2), .alu_acode(alu_acode2),
    .alu_r(alu_r2), .alu_zero(alu_zero2), .alu_cout(alu_cout2),
    .out_valid(out_valid2), .out_ready(out_ready), .res_code(res_code2), .res_r(res_r2),
    .res_zero(res_zero2), .res_cout(res_cout2), .busy(busy2), .done(done2),
    .zero_count(zero_count2)
  );

  typedef struct {
    logic       mode;
    logic [7:0] a;
    logic [2:0] code;
    logic [7:0] r;
    logic       z;
    logic       c;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || busy2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy || busy2) chk("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // Run one full sweep of table entries [first, first+n) on the SETTLE=1 instance.
  task automatic run_table(input int first, input int n, input int exp_done_cyc,
                           input logic [3:0] exp_zc);
    int idx;
    int done_cyc;
    int first_valid;
    idx = first;
    done_cyc = -1;
    first_valid = -1;
    mode = vecs[first].mode;
    a_in = vecs[first].a;
    b_in = 8'h5A;
    cin_in = 1'b1;
    out_ready = 1'b1;
    start = 1'b1;
    for (int cyc = 1; cyc <= 60 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (idx < first + n) begin
          chk("tbl_code", 32'(res_code), 32'(vecs[idx].code));
          chk("tbl_r", 32'(res_r), 32'(vecs[idx].r));
          chk("tbl_zero", 32'(res_zero), 32'(vecs[idx].z));
          chk("tbl_cout", 32'(res_cout), 32'(vecs[idx].c));
          chk("tbl_acode", 32'(alu_acode), vecs[idx].mode ? 32'd0 : 32'(vecs[idx].code));
          chk("tbl_scode", 32'(alu_scode), vecs[idx].mode ? 32'(vecs[idx].code) : 32'd0);
        end else begin
          chk("tbl_extra_result", 32'(res_code), 32'hFFFF);
        end
        idx++;
      end
      if (done) done_cyc = cyc;
    end
    chk("tbl_n_results", 32'(idx - first), 32'(n));
    chk("tbl_first_valid_cyc", 32'(first_valid), 32'd2);
    chk("tbl_done_cyc", 32'(done_cyc), 32'(exp_done_cyc));
    chk("tbl_zero_count", 32'(zero_count), 32'(exp_zc));
    chk("tbl_is_shift", 32'(alu_is_shift), 32'(vecs[first].mode));
    chk("tbl_alu_b", 32'(alu_b), 32'h5A);
    chk("tbl_alu_cin", 32'(alu_cin), 32'd1);
    @(negedge clk);
    chk("tbl_done_one_cycle", 32'(done), 32'd0);
    chk("tbl_busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    bit ok;
    bit found;
    int nres;
    int first;
    int n3;
    int dcyc;
    logic [7:0] r0;
    logic [7:0] exp_r;
    bit done_seen;

    vecs[0]  = '{1'b0, 8'hFB, 3'd0, 8'hFB, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'hFB, 3'd1, 8'hFC, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'hFB, 3'd2, 8'hFD, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'hFB, 3'd3, 8'hFE, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'hFB, 3'd4, 8'hFF, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'hFB, 3'd5, 8'h00, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 8'hFB, 3'd6, 8'h01, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 8'hFB, 3'd7, 8'h02, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 8'h10, 3'd0, 8'h10, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'h10, 3'd1, 8'h11, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h10, 3'd2, 8'h12, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'h10, 3'd3, 8'h13, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_zero_count", 32'(zero_count), 32'd0);
    chk("rst_res_r", 32'(res_r), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_alu_misc", 32'({alu_cin, alu_is_shift, alu_scode, alu_acode}), 32'd0);
    chk("rst3_misc", 32'({alu_b2, alu_cin2, alu_is_shift2, out_valid2, busy2}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Arith sweep A=FB and shift sweep A=10
    wait_idle();
    run_table(0, 8, 17, 4'd1);
    wait_idle();
    run_table(8, 4, 9, 4'd0);

    // Back-pressure on code 2: result must hold, no skip or repeat
    wait_idle();
    mode = 1'b0; a_in = 8'hFB; out_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      wait_valid(ok);
      if (!ok) break;
      exp_r = 8'hFB + 8'(k);
      chk("bp_code", 32'(res_code), 32'(k));
      chk("bp_r", 32'(res_r), 32'(exp_r));
      if (k == 2) begin
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          chk("bp_hold_valid", 32'(out_valid), 32'd1);
          chk("bp_hold_code", 32'(res_code), 32'd2);
          chk("bp_hold_r", 32'(res_r), 32'hFD);
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    chk("bp_done", 32'(done), 32'd1);

    // Abort on code 4 with a coincident handshake; start while busy is ignored
    wait_idle();
    mode = 1'b0; a_in = 8'hFB; out_ready = 1'b1; start = 1'b1;
    nres = 0;
    found = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) begin
        chk("ab_code", 32'(res_code), 32'(nres));
        nres++;
        if (res_code == 3'd2) begin
          start = 1'b1;
          a_in = 8'h00;
        end
        if (res_code == 3'd3) chk("ab_r_code3", 32'(res_r), 32'hFE);
        if (res_code == 3'd4) begin
          abort = 1'b1;
          found = 1'b1;
          break;
        end
      end
    end
    chk("ab_reached_code4", 32'(found), 32'd1);
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_valid", 32'(out_valid), 32'd0);
    done_seen = done;
    repeat (3) begin
      @(negedge clk);
      done_seen = done_seen | done;
    end
    chk("ab_no_done", 32'(done_seen), 32'd0);
    chk("ab_n_results", 32'(nres), 32'd5);

    // SETTLE=3 instance: latency, code hold time, sweep length
    wait_idle();
    mode = 1'b0; a_in = 8'hFB; out_ready = 1'b1; start = 1'b1;
    first = -1; n3 = 0; dcyc = -1; r0 = 8'hAA;
    for (int cyc = 1; cyc <= 80 && dcyc < 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid2 && first < 0) begin
        first = cyc;
        r0 = res_r2;
        chk("s3_first_code", 32'(res_code2), 32'd0);
      end
      if (busy2 && !out_valid2 && alu_acode2 == 3'd3) n3++;
      if (done2) dcyc = cyc;
    end
    chk("s3_first_valid_cyc", 32'(first), 32'd4);
    chk("s3_first_r", 32'(r0), 32'hFB);
    chk("s3_acode3_drive_cycles", 32'(n3), 32'd3);
    chk("s3_done_cyc", 32'(dcyc), 32'd33);
    chk("s3_zero_count", 32'(zero_count2), 32'd1);
    chk("s3_last_flags", 32'({res_zero2, res_cout2}), 32'b01);

    // start and abort together stay in IDLE
    wait_idle();
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy), 32'd0);
    chk("sa_busy3", 32'(busy2), 32'd0);

    // Reset while holding a result in PRESENT
    wait_idle();
    mode = 1'b0; a_in = 8'hFF; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (out_valid && res_code == 3'd2) begin
        out_ready = 1'b0;
        found = 1'b1;
        break;
      end
    end
    chk("rp_reached_code2", 32'(found), 32'd1);
    chk("rp_pre_zero_count", 32'(zero_count), 32'd1);
    chk("rp_pre_r", 32'(res_r), 32'h01);
    rst_n = 1'b0;
    #1;
    chk("rp_valid", 32'(out_valid), 32'd0);
    chk("rp_busy", 32'(busy), 32'd0);
    chk("rp_r", 32'(res_r), 32'd0);
    chk("rp_zero_count", 32'(zero_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rp_idle_busy", 32'(busy), 32'd0);
    chk("rp_idle_valid_done", 32'({out_valid, done}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
